// File: rtl/mem_array_pingpong_ctrl.sv
// Write-side sequencer and bank hand-off control for the two-bank ping-pong IFM array.
// The producer fills one bank while the consumer reads the other; a full bank is
// handed over (ifm_sel toggles) only once the consumer has released its bank.
module mem_array_pingpong_ctrl #(
  parameter int unsigned IFM_SIZE         = 28,
  parameter int unsigned NUMBER_OF_IFM    = 2,
  parameter int unsigned ADDRESS_SIZE_IFM = $clog2(IFM_SIZE * IFM_SIZE),
  localparam int unsigned IDX_W           = (NUMBER_OF_IFM > 1) ? $clog2(NUMBER_OF_IFM) : 1
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        prev_wr_valid,
  output logic                        prev_wr_ready,
  output logic                        ifm_enable_write_previous,
  output logic [ADDRESS_SIZE_IFM-1:0] ifm_address_write_previous,
  output logic                        ifm_sel,
  output logic                        next_frame_valid,
  input  logic                        next_done,
  output logic [IDX_W-1:0]            next_ifm_idx,
  output logic                        next_last_ifm,
  output logic                        swap_pulse
);

  localparam int unsigned WORDS = IFM_SIZE * IFM_SIZE;
  localparam logic [ADDRESS_SIZE_IFM-1:0] LAST_ADDR = ADDRESS_SIZE_IFM'(WORDS - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUMBER_OF_IFM - 1);

  typedef enum logic {
    ST_FILL = 1'b0,
    ST_FULL = 1'b1
  } state_t;

  state_t                      state_q, state_d;
  logic [ADDRESS_SIZE_IFM-1:0] wr_cnt_q, wr_cnt_d;
  logic                        ifm_sel_q, ifm_sel_d;
  logic                        rd_busy_q, rd_busy_d;
  logic [IDX_W-1:0]            wr_idx_q, wr_idx_d;
  logic [IDX_W-1:0]            rd_idx_q, rd_idx_d;
  logic                        swap_pulse_q, swap_pulse_d;
  logic                        fill;
  logic                        accept;
  logic                        swap;

  // Handshake and write port decode; zero latency from valid to the array.
  assign fill   = (state_q == ST_FILL);
  assign accept = prev_wr_valid & fill;
  assign swap   = (state_q == ST_FULL) & (~rd_busy_q | next_done);

  assign prev_wr_ready              = fill;
  assign ifm_enable_write_previous  = accept;
  assign ifm_address_write_previous = wr_cnt_q;
  assign ifm_sel                    = ifm_sel_q;
  assign next_frame_valid           = rd_busy_q;
  assign next_ifm_idx               = rd_idx_q;
  assign next_last_ifm              = rd_busy_q & (rd_idx_q == LAST_IDX);
  assign swap_pulse                 = swap_pulse_q;

  // Next-state logic: word counting in FILL, bank hand-off in FULL.
  always_comb begin
    state_d      = state_q;
    wr_cnt_d     = wr_cnt_q;
    ifm_sel_d    = ifm_sel_q;
    rd_busy_d    = rd_busy_q;
    wr_idx_d     = wr_idx_q;
    rd_idx_d     = rd_idx_q;
    swap_pulse_d = 1'b0;

    // Consumer release; overridden below when a swap re-claims the bank.
    if (next_done && rd_busy_q) begin
      rd_busy_d = 1'b0;
    end

    unique case (state_q)
      ST_FILL: begin
        if (accept) begin
          if (wr_cnt_q == LAST_ADDR) begin
            wr_cnt_d = '0;
            state_d  = ST_FULL;
          end else begin
            wr_cnt_d = wr_cnt_q + ADDRESS_SIZE_IFM'(1);
          end
        end
      end
      ST_FULL: begin
        if (swap) begin
          ifm_sel_d    = ~ifm_sel_q;
          rd_busy_d    = 1'b1;
          rd_idx_d     = wr_idx_q;
          wr_idx_d     = (wr_idx_q == LAST_IDX) ? '0 : wr_idx_q + IDX_W'(1);
          state_d      = ST_FILL;
          swap_pulse_d = 1'b1;
        end
      end
      default: begin
        state_d = ST_FILL;
      end
    endcase
  end

  // State and counter registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_FILL;
      wr_cnt_q     <= '0;
      ifm_sel_q    <= 1'b0;
      rd_busy_q    <= 1'b0;
      wr_idx_q     <= '0;
      rd_idx_q     <= '0;
      swap_pulse_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_cnt_q     <= wr_cnt_d;
      ifm_sel_q    <= ifm_sel_d;
      rd_busy_q    <= rd_busy_d;
      wr_idx_q     <= wr_idx_d;
      rd_idx_q     <= rd_idx_d;
      swap_pulse_q <= swap_pulse_d;
    end
  end

endmodule

// File: doc/mem_array_pingpong_ctrl.md
Name: mem_array_pingpong_ctrl

Overview:
Sequencer for the two-bank ping-pong IFM memory array (Mem1/Mem2, selected by ifm_sel).
- Accepts the previous layer's output stream and generates the write-side enable and address.
- Decides when the filled bank is handed to the next layer and toggles ifm_sel.
- Tracks consumer occupancy and the IFM index within a layer, so producer and consumer never touch the same bank.

Parameters:
IFM_SIZE, 28, feature-map side length; words per frame = IFM_SIZE*IFM_SIZE.
NUMBER_OF_IFM, 2, feature maps per layer; frame index wraps after this count.
ADDRESS_SIZE_IFM, $clog2(IFM_SIZE*IFM_SIZE), width of the word address.

Ports:
clk  input  1  clock, all logic on rising edge.
reset  input  1  synchronous, active-high reset.
prev_wr_valid  input  1  previous layer presents a data word this cycle.
prev_wr_ready  output  1  controller can accept a word into the write bank.
ifm_enable_write_previous  output  1  write strobe to the array = prev_wr_valid & prev_wr_ready.
ifm_address_write_previous  output  ADDRESS_SIZE_IFM  write address = current word counter.
ifm_sel  output  1  bank select: 0 = Mem1 write / Mem2 read; 1 = Mem2 write / Mem1 read.
next_frame_valid  output  1  read bank holds a complete frame owned by the next layer.
next_done  input  1  one-cycle pulse: next layer finished reading the read bank.
next_ifm_idx  output  $clog2(NUMBER_OF_IFM) (min 1)  index of the frame in the read bank.
next_last_ifm  output  1  next_frame_valid and next_ifm_idx == NUMBER_OF_IFM-1.
swap_pulse  output  1  one-cycle pulse in the cycle after ifm_sel toggles.

Behaviour:
- State machine states: FILL, FULL. The controller also holds rd_busy (read-bank owned by consumer), wr_cnt, wr_idx (index of the frame being written) and next_ifm_idx.
- Reset values: state=FILL, wr_cnt=0, ifm_sel=0, rd_busy=0, wr_idx=0, next_ifm_idx=0, swap_pulse=0.
- Resulting outputs after reset: prev_wr_ready=1, next_frame_valid=0, next_last_ifm=0.
- prev_wr_ready is 1 only in FILL. The write strobe and address are combinational from valid, state and wr_cnt, giving zero latency to the array.
- FILL, on accept:
  - wr_cnt increments.
  - If wr_cnt == IFM_SIZE*IFM_SIZE-1: wr_cnt goes to 0 and state goes to FULL.
- FULL, swap condition = (!rd_busy) | next_done:
  - ifm_sel toggles; rd_busy goes to 1; next_ifm_idx is set to wr_idx.
  - wr_idx increments, wrapping to 0 after NUMBER_OF_IFM-1.
  - state goes to FILL; swap_pulse is 1 on the following cycle.
- Latency: last word accepted in cycle N.
  - With the reader idle: FULL in N+1, swap at end of N+1, prev_wr_ready=1 and next_frame_valid=1 in N+2.
  - If the reader is busy: FULL holds (prev_wr_ready=0, producer stalls) until next_done.
- next_done while rd_busy=1 and no swap: rd_busy goes to 0. next_done while rd_busy=0 is ignored.
- Simultaneous next_done and FULL: the swap takes priority and rd_busy stays 1. A new frame is presented with no idle cycle.
- next_frame_valid = rd_busy.
- The producer may hold prev_wr_valid low at any time. wr_cnt holds and no write strobe is issued.
- Reset mid-frame: the partial frame is discarded, the read bank is released, and ifm_sel returns to 0. Memory contents are not cleared.
- NUMBER_OF_IFM=1: wr_idx and next_ifm_idx are constant 0, and next_last_ifm = next_frame_valid.

Test Plan:
- Reset, then stream 784 words with continuous valid: addresses 0..783 with write strobe each cycle. FULL 1 cycle, then ifm_sel goes 0->1, next_frame_valid=1, next_ifm_idx=0, swap_pulse one cycle. prev_wr_ready drops for exactly 1 cycle.
- Second frame of 784 words while next_done is withheld: prev_wr_ready stays 0 after word 783 and ifm_sel stays 1. Pulse next_done: swap in that cycle, ifm_sel=0, next_ifm_idx=1, next_last_ifm=1, next_frame_valid stays 1.
- next_done in the same cycle FULL is entered: immediate swap and rd_busy remains 1. A third frame wraps next_ifm_idx to 0.
- Random valid gaps (valid 50%): exactly 784 strobes with addresses strictly sequential. No strobe when valid=0 and no address skip.
- Assert reset at word 400: next cycle wr_cnt=0, ifm_sel=0, next_frame_valid=0, prev_wr_ready=1. The following frame starts at address 0.
- Spurious next_done with next_frame_valid=0: no state change, and ifm_sel and counters are unchanged.
